// File: rtl/seg_7_reader_pkg.sv
// Shared 7-segment definitions: active-low glyphs (a..g, dp), special nibbles,
// and the decode result type used by the segment reader.
package seg_7_reader_pkg;

  localparam int DIGITS = 4;

  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam logic [3:0] NIB_ERR   = 4'hE;

  // Bit 7 = a ... bit 1 = g, bit 0 = dp; all glyphs carry an unlit dp.
  localparam logic [7:0] SEG_0     = 8'b0000_0011;
  localparam logic [7:0] SEG_1     = 8'b1001_1111;
  localparam logic [7:0] SEG_2     = 8'b0010_0101;
  localparam logic [7:0] SEG_3     = 8'b0000_1101;
  localparam logic [7:0] SEG_4     = 8'b1001_1001;
  localparam logic [7:0] SEG_5     = 8'b0100_1001;
  localparam logic [7:0] SEG_6     = 8'b0100_0001;
  localparam logic [7:0] SEG_7     = 8'b0001_1111;
  localparam logic [7:0] SEG_8     = 8'b0000_0001;
  localparam logic [7:0] SEG_9     = 8'b0000_1001;
  localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

  typedef struct packed {
    logic [3:0] value;
    logic       illegal;
  } decode_t;

endpackage

// File: rtl/seg_7_pattern_decoder.sv
// Combinational reverse lookup of a 7-bit segment pattern (a..g) into a nibble,
// flagging anything that is not a digit glyph or blank.
module seg_7_pattern_decoder
  import seg_7_reader_pkg::*;
(
  input  logic [6:0] pattern,
  output decode_t    result
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result = '{value: NIB_ERR, illegal: 1'b1};
    case (pattern)
      SEG_0[7:1]:     result = '{value: 4'h0, illegal: 1'b0};
      SEG_1[7:1]:     result = '{value: 4'h1, illegal: 1'b0};
      SEG_2[7:1]:     result = '{value: 4'h2, illegal: 1'b0};
      SEG_3[7:1]:     result = '{value: 4'h3, illegal: 1'b0};
      SEG_4[7:1]:     result = '{value: 4'h4, illegal: 1'b0};
      SEG_5[7:1]:     result = '{value: 4'h5, illegal: 1'b0};
      SEG_6[7:1]:     result = '{value: 4'h6, illegal: 1'b0};
      SEG_7[7:1]:     result = '{value: 4'h7, illegal: 1'b0};
      SEG_8[7:1]:     result = '{value: 4'h8, illegal: 1'b0};
      SEG_9[7:1]:     result = '{value: 4'h9, illegal: 1'b0};
      SEG_BLANK[7:1]: result = '{value: NIB_BLANK, illegal: 1'b0};
      default:        result = '{value: NIB_ERR, illegal: 1'b1};
    endcase
  end

endmodule

// File: rtl/seg_7_reader.sv
// Reads a multiplexed active-low 7-segment bus: synchronizes the pins, waits for
// a stable pattern on a single enabled digit, then decodes and stores it.
module seg_7_reader
  import seg_7_reader_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            seg,
  input  logic [DIGITS-1:0]     dig,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic                  valid,
  output logic                  update,
  output logic                  err
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);

  logic [7:0]        seg_s1, seg_s2;
  logic [DIGITS-1:0] dig_s1, dig_s2;
  logic [11:0]       prev;
  logic [7:0]        cnt;
  logic [DIGITS-1:0] seen;
  logic              match, one_low, accept;
  logic [1:0]        idx;
  decode_t           dec;

  seg_7_pattern_decoder u_dec (
    .pattern (seg_s2[7:1]),
    .result  (dec)
  );

  assign match   = ({seg_s2, dig_s2} == prev);
  assign one_low = ($countones(~dig_s2) == 1);
  // Fires on the single cycle the run length reaches the threshold; the
  // saturated counter never revisits CNT_LAST without a fresh mismatch.
  assign accept  = match && (cnt == CNT_LAST) && one_low;
  assign valid   = &seen;

  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dig_s2[i]) idx = 2'(i);
    end
  end

  // Synchronizers and history reset to the inactive (all-ones) bus state so a
  // pattern held across reset must still serve the full latency afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_s1 <= '1;
      seg_s2 <= '1;
      dig_s1 <= '1;
      dig_s2 <= '1;
      prev   <= '1;
      cnt    <= '0;
      value  <= '1;
      dp     <= '0;
      seen   <= '0;
      update <= 1'b0;
      err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      dig_s1 <= dig;
      dig_s2 <= dig_s1;
      prev   <= {seg_s2, dig_s2};
      if (!match)              cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
      update <= accept;
      err    <= accept && dec.illegal;
      if (accept) begin
        value[{idx, 2'b00} +: 4] <= dec.value;
        dp[idx]                  <= ~seg_s2[0];
        seen[idx]                <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg_7_reader.sv
// Self-checking bench for seg_7_reader: directed plan steps plus random holds,
// compared every cycle against a sample-history reference model.
module tb_seg_7_reader;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        valid, update, err;

  always #5 clk = ~clk;

  seg_7_reader #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst    (rst),
    .seg    (seg),
    .dig    (dig),
    .value  (value),
    .dp     (dp),
    .valid  (valid),
    .update (update),
    .err    (err)
  );

  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  int err_seen = 0;

  // Digit glyphs a..g, 0 = lit.
  logic [6:0]  glyph [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                              7'b0000000, 7'b0000100};
  logic [11:0] hist [16];
  logic [15:0] exp_value;
  logic [3:0]  exp_dp, exp_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return {1'b0, 4'hF};
    for (int v = 0; v < 10; v++)
      if (glyph[v] == p) return {1'b0, 4'(v)};
    return {1'b1, 4'hE};
  endfunction

  function automatic int zeros(input logic [3:0] d);
    int n = 0;
    for (int i = 0; i < 4; i++) if (!d[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    exp_value = 16'hFFFF;
    exp_dp    = 4'h0;
    exp_seen  = 4'h0;
    for (int i = 0; i < 16; i++) hist[i] = 12'hFFF;
  endtask

  // One clock: record the sample, decide from the history whether a run of S+1
  // equal samples ending two edges ago has just completed, then check outputs.
  task automatic step();
    logic       acc;
    logic [4:0] dcd;
    @(posedge clk);
    for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {seg, dig};
    acc = (zeros(hist[2][3:0]) == 1) && (hist[3+S] != hist[2]);
    for (int i = 3; i <= 2 + S; i++) if (hist[i] != hist[2]) acc = 1'b0;
    dcd = ref_decode(hist[2][11:5]);
    if (acc) begin
      for (int d = 0; d < 4; d++) begin
        if (!hist[2][d]) begin
          exp_value[d*4 +: 4] = dcd[3:0];
          exp_dp[d]           = ~hist[2][4];
          exp_seen[d]         = 1'b1;
        end
      end
    end
    #1;
    check("update", 32'(update), 32'(acc));
    check("err", 32'(err), 32'(acc && dcd[4]));
    check("value", 32'(value), 32'(exp_value));
    check("dp", 32'(dp), 32'(exp_dp));
    check("valid", 32'(valid), 32'(&exp_seen));
    if (update) upd_seen++;
    if (err) err_seen++;
  endtask

  task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
    seg = s;
    dig = d;
    repeat (n) step();
  endtask

  task automatic gap(input int n);
    hold(8'hFF, 4'hF, n);
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, then releases on a
  // falling edge with the caller's next inputs already applied.
  task automatic do_reset(input logic [7:0] s, input logic [3:0] d);
    #2 rst = 1'b1;
    #1;
    check("rst_value", 32'(value), 32'hFFFF);
    check("rst_dp", 32'(dp), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    model_reset();
    seg = s;
    dig = d;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] v0;
    logic [7:0]  rs;
    logic [3:0]  rd;
    rst = 1'b1;
    seg = 8'hFF;
    dig = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gap(4);

    // Reset during a run, then first-capture latency.
    hold({glyph[5], 1'b1}, 4'b1011, 3);
    do_reset(8'b0000_0011, 4'b1110);
    upd_seen = 0;
    repeat (6) step();
    check("latency_early", 32'(upd_seen), 32'd0);
    step();
    check("latency_update", 32'(update), 32'd1);
    check("latency_nibble", 32'(value[3:0]), 32'h0);
    step();
    check("latency_pulse", 32'(update), 32'd0);
    gap(3);

    // 1,2,3,4 on digits 3..0; VALID only on the fourth capture.
    do_reset(8'hFF, 4'hF);
    for (int i = 0; i < 4; i++) begin
      hold({glyph[i+1], 1'b1}, 4'(~(4'b0001 << (3 - i))), 10);
      gap(3);
      if (i == 2) check("valid_after_3", 32'(valid), 32'd0);
    end
    check("value_1234", 32'(value), 32'h1234);
    check("valid_after_4", 32'(valid), 32'd1);

    // Every glyph and blank on every digit.
    upd_seen = 0;
    for (int d = 0; d < 4; d++) begin
      for (int g = 0; g < 11; g++) begin
        hold((g < 10) ? {glyph[g], 1'b1} : 8'hFF, 4'(~(4'b0001 << d)), 10);
        gap(3);
      end
    end
    check("sweep_updates", 32'(upd_seen), 32'd44);
    check("sweep_value", 32'(value), 32'hFFFF);

    // Decimal point.
    hold(8'b1001_1110, 4'b1101, 10);
    gap(3);
    check("dp_nibble", 32'(value[7:4]), 32'h1);
    check("dp_bits", 32'(dp), 32'b0010);

    // Glitch: a 3-cycle change never lands; the restored pattern re-captures later.
    hold({glyph[7], 1'b1}, 4'b1110, 10);
    v0 = value;
    upd_seen = 0;
    hold({glyph[8], 1'b1}, 4'b1110, 3);
    hold({glyph[7], 1'b1}, 4'b1110, 5);
    check("glitch_updates", 32'(upd_seen), 32'd0);
    check("glitch_value", 32'(value), 32'(v0));
    hold({glyph[7], 1'b1}, 4'b1110, 10);
    upd_seen = 0;
    hold({glyph[2], 1'b1}, 4'b1110, 4);
    gap(10);
    check("short_run_updates", 32'(upd_seen), 32'd0);
    upd_seen = 0;
    hold({glyph[2], 1'b1}, 4'b1110, 6);
    gap(10);
    check("six_hold_updates", 32'(upd_seen), 32'd1);
    check("six_hold_nibble", 32'(value[3:0]), 32'h2);

    // Illegal glyph.
    upd_seen = 0;
    err_seen = 0;
    hold(8'b0101_0101, 4'b0111, 10);
    gap(3);
    check("illegal_nibble", 32'(value[15:12]), 32'hE);
    check("illegal_updates", 32'(upd_seen), 32'd1);
    check("illegal_errs", 32'(err_seen), 32'd1);

    // Bad enables.
    upd_seen = 0;
    hold({glyph[3], 1'b1}, 4'b1100, 20);
    hold({glyph[3], 1'b1}, 4'b1111, 20);
    check("bad_enable_updates", 32'(upd_seen), 32'd0);

    // Random holds: mostly legal glyphs on single digits, some noise.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    rs = 8'($urandom);
        2:       rs = 8'hFF;
        default: rs = {glyph[$urandom_range(0, 9)], 1'($urandom)};
      endcase
      if ($urandom_range(0, 9) < 7) rd = 4'(~(4'b0001 << $urandom_range(0, 3)));
      else                          rd = 4'($urandom);
      hold(rs, rd, $urandom_range(1, 12));
    end
    gap(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
